// File: rtl/uart_rx_deframer_if.sv
// Received-byte bus from the UART deframer to the register/FIFO stage.
// The master drives a byte with its error flags; data_valid pulses for one cycle
// whenever data and flags are updated, and all three stay held until the next frame.
interface uart_rx_deframer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output data,
        output data_valid,
        output parity_err,
        output frame_err
    );

    modport slave (
        input data,
        input data_valid,
        input parity_err,
        input frame_err
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer. Synchronises rx_i, detects a start bit, enables the
// baud generator for the length of a frame, samples each bit at mid-bit and
// delivers the byte with parity/framing error flags over rx_if.
module uart_rx_deframer #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   rx_i,
    input  logic                   cfg_parity_en_i,
    input  logic                   cfg_parity_odd_i,
    output logic                   gen_en_o,
    input  logic                   bit_done_i,
    input  logic                   bit_half_done_i,
    output logic                   busy_o,
    uart_rx_deframer_if.master     rx_if
);

    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_q;
    logic                   rx_fall;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;

    // Synchroniser chain plus one delay stage for edge detection; resets to idle-high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
            rx_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_q   <= rx_s;
        end
    end

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign rx_fall = rx_q & ~rx_s;

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic: sample on the half pulse first, then advance on bit_done.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        unique case (state_q)
            StIdle: begin
                if (rx_fall) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // A line that is high again at mid-bit was a glitch, not a start bit.
                if (bit_half_done_i && rx_s) begin
                    state_d = StIdle;
                end else if (bit_done_i) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (bit_half_done_i) begin
                    shift_d[idx_q] = rx_s;
                end
                if (bit_done_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = cfg_parity_en_i ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_half_done_i) begin
                    par_bit_d = rx_s;
                end
                if (bit_done_i) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                // Finish at mid stop bit so an immediately following start bit is caught.
                if (bit_half_done_i) begin
                    data_d  = shift_q;
                    perr_d  = cfg_parity_en_i ?
                              ((^shift_q ^ par_bit_q) != cfg_parity_odd_i) : 1'b0;
                    ferr_d  = ~rx_s;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign gen_en_o         = (state_q != StIdle);
    assign busy_o           = (state_q != StIdle);
    assign rx_if.data       = data_q;
    assign rx_if.data_valid = valid_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.frame_err  = ferr_q;

endmodule
